i2c_master_seq: RTL and testbench
=================================

// Module: i2c_master_seq
// PURPOSE
//   Byte-level I2C master sequencer that drives the open-drain SDA/SCL pins of the I2C peripheral.
//   Executes one command per handshake: START, WRITE byte, READ byte, STOP.
//   Returns the received ACK or the read data on a response strobe.
//   Sits between the AXI4-Lite register file (command source) and the pad-level open-drain drivers.
// PARAMETERS
//   CLK_DIV   125   clk cycles per quarter SCL period (SCL = clk/(4*CLK_DIV)); legal range 2..65535
// PORTS
//   clk         in   1  clock
//   resetn      in   1  synchronous, active-low reset
//   cmd_valid   in   1  command present
//   cmd_ready   out  1  sequencer can accept a command (1 only in IDLE)
//   cmd_op      in   2  0=START (also repeated START), 1=WRITE, 2=READ, 3=STOP
//   cmd_data    in   8  byte to transmit on WRITE, MSB first
//   cmd_nack    in   1  READ only: 1 = send NACK after the byte, 0 = send ACK
//   rsp_valid   out  1  one-cycle pulse: command complete
//   rsp_data    out  8  READ data; holds its last value otherwise
//   rsp_ack_n   out  1  WRITE: sampled ACK bit (0 = slave ACKed)
//   rsp_err     out  1  command rejected (see BEHAVIOUR)
//   busy        out  1  state != IDLE
//   bus_active  out  1  set by START, cleared by STOP
//   sda_i       in   1  SDA pin level
//   scl_i       in   1  SCL pin level
//   sda_oe      out  1  1 = pull SDA low, 0 = release
//   scl_oe      out  1  1 = pull SCL low, 0 = release
// BEHAVIOUR
//   Reset values:
//     - sda_oe=0, scl_oe=0, rsp_valid=0, rsp_data=0, rsp_ack_n=0, rsp_err=0, busy=0, bus_active=0.
//     - State is IDLE, so cmd_ready=1 from the first cycle after reset.
//   Handshake:
//     - A command is accepted when cmd_valid && cmd_ready.
//     - cmd_op, cmd_data and cmd_nack are captured on acceptance; later changes to the inputs are ignored.
//     - cmd_ready falls on the next cycle.
//   Phase timer:
//     - A counter runs 0..CLK_DIV-1; a phase advances when the counter reaches CLK_DIV-1.
//     - Every bus element (START, data bit, ACK bit, STOP) is exactly 4 phases, P0..P3.
//   Clock stretching:
//     - In P2 with scl_oe=0, the counter is frozen while scl_i==0.
//     - The phase completes CLK_DIV cycles after scl_i is first seen high.
//   States and transitions:
//     - IDLE -> START | WBIT | RBIT | STOP on accept.
//     - Each state returns to IDLE with a 1-cycle rsp_valid pulse in the cycle after the final P3 ends.
//   START:
//     - P0 release SDA; P1 release SCL; P2 release SCL (stretch wait); P3 sda_oe=1; end with scl_oe=1.
//     - Sets bus_active.
//     - Legal while bus_active=1 (repeated START).
//   WBIT, 9 bits (8 data bits then ACK):
//     - P0 scl_oe=1, sda_oe=~bit; P1 scl_oe=0; P2 high/stretch; P3 scl_oe=1.
//     - The ACK bit releases SDA; rsp_ack_n = sda_i sampled on the last cycle of P2.
//   RBIT:
//     - Data bits release SDA and sample sda_i at the end of P2, shifting MSB first into rsp_data.
//     - The 9th bit drives sda_oe = ~cmd_nack.
//   STOP:
//     - P0 scl_oe=1, sda_oe=1; P1 scl_oe=0; P2 stretch; P3 sda_oe=0.
//     - Clears bus_active.
//   Latency (CLK_DIV=N, no stretch):
//     - START and STOP: 4N cycles.
//     - WRITE and READ: 36N cycles.
//     - Each is followed by 1 cycle for rsp_valid.
//   Rejected commands:
//     - WRITE, READ or STOP with bus_active=0 causes no pin activity.
//     - rsp_valid=1 with rsp_err=1 two cycles after accept; rsp_data and rsp_ack_n are unchanged.
//   Reset mid-operation:
//     - On the next edge, pins are released and state returns to IDLE; no rsp_valid is produced.
//   Other rules:
//     - The counter is width-sized for CLK_DIV and never wraps inside a phase.
//     - Between commands the sequencer holds scl_oe, so SCL stays low while bus_active=1.
// TESTING (CLK_DIV=4, open-drain pull-up model, slave BFM)
//   1. START, WRITE 0xA5 with slave ACK, STOP
//      -> SDA bits at SCL rising edges are 1,0,1,0,0,1,0,1; rsp_ack_n=0; WRITE rsp_valid 145 cycles after accept.
//   2. START, READ with slave sending 0x3C, cmd_nack=1, STOP
//      -> rsp_data=0x3C; SDA released during the 9th SCL high; STOP is SDA rising while SCL is high.
//   3. WRITE with no slave ACK -> rsp_ack_n=1.
//   4. Slave holds SCL low for 20 cycles in bit 3 of a WRITE -> completion delayed by exactly 20 cycles.
//   5. WRITE at bus_active=0
//      -> rsp_err=1 two cycles after accept; sda_oe and scl_oe stay 0 throughout.
//   6. START, WRITE, then resetn=0 mid-byte for 1 cycle
//      -> sda_oe=scl_oe=0 next edge; cmd_ready=1; no rsp_valid; bus_active=0.
//      Also: START twice (repeated START) -> the second START produces SDA falling while SCL is high.

Source files
------------

// File: rtl/i2c_master_seq_if.sv
// Command/response handshake and open-drain pin bundle for the byte-level I2C master sequencer.
// The master modport is the sequencer's view; the slave modport is the command source / pad side.
interface i2c_master_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_nack;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ack_n;
  logic       rsp_err;
  logic       busy;
  logic       bus_active;
  logic       sda_i;
  logic       scl_i;
  logic       sda_oe;
  logic       scl_oe;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, cmd_nack, sda_i, scl_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_ack_n, rsp_err, busy, bus_active, sda_oe, scl_oe
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, cmd_nack, sda_i, scl_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ack_n, rsp_err, busy, bus_active, sda_oe, scl_oe
  );
endinterface

// File: rtl/i2c_master_seq.sv
// Byte-level I2C master sequencer: one command (START, WRITE, READ, STOP) per handshake,
// each bus element is four CLK_DIV-cycle phases, with SCL stretching honoured in phase P2.
module i2c_master_seq #(
  parameter int unsigned CLK_DIV = 125
) (
  input logic              clk,
  input logic              resetn,
  i2c_master_seq_if.master bus
);

  localparam int unsigned   CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, WBIT, RBIT, STOP, ERR} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    phase;
  logic [3:0]    bit_idx;
  logic [7:0]    sh;
  logic          nack;

  state_t        acc_state;
  logic          reject;
  logic          stretch;
  logic          phase_end;
  logic          last_bit;
  logic          final_elem;
  logic          sample;

  function automatic state_t op_state(input logic [1:0] op);
    case (op)
      2'd0:    return START;
      2'd1:    return WBIT;
      2'd2:    return RBIT;
      default: return STOP;
    endcase
  endfunction

  // Pin levels {scl_oe, sda_oe} for a given element and phase.
  function automatic logic [1:0] pins(input state_t st, input logic [1:0] ph, input logic lastb,
                                      input logic dbit, input logic nk, input logic scl_now);
    logic [1:0] p;
    logic       s;
    p = {scl_now, 1'b0};
    s = 1'b0;
    case (st)
      START: p = (ph == 2'd0) ? {scl_now, 1'b0} : (ph == 2'd3) ? 2'b01 : 2'b00;
      WBIT, RBIT: begin
        if (lastb) s = (st == RBIT) ? ~nk : 1'b0;
        else       s = (st == WBIT) ? ~dbit : 1'b0;
        p = {(ph == 2'd0) || (ph == 2'd3), s};
      end
      STOP:    p = (ph == 2'd0) ? 2'b11 : (ph == 2'd3) ? 2'b00 : 2'b01;
      default: p = {scl_now, 1'b0};
    endcase
    return p;
  endfunction

  // Phase timing, stretch detection and acceptance decode.
  always_comb begin
    acc_state  = op_state(bus.cmd_op);
    reject     = (bus.cmd_op != 2'd0) && !bus.bus_active;
    stretch    = (phase == 2'd2) && !bus.scl_oe && !bus.scl_i;
    phase_end  = (cnt == CNT_LAST) && !stretch;
    last_bit   = (bit_idx == 4'd8);
    final_elem = (state == START) || (state == STOP) || last_bit;
    sample     = phase_end && (phase == 2'd2);
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

  // Sequencer FSM with registered pin drives and response outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      cnt            <= '0;
      phase          <= '0;
      bit_idx        <= '0;
      sh             <= '0;
      nack           <= 1'b0;
      bus.sda_oe     <= 1'b0;
      bus.scl_oe     <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_ack_n  <= 1'b0;
      bus.rsp_err    <= 1'b0;
      bus.bus_active <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cnt     <= '0;
            phase   <= '0;
            bit_idx <= '0;
            sh      <= bus.cmd_data;
            nack    <= bus.cmd_nack;
            if (reject) begin
              state <= ERR;
            end else begin
              state <= acc_state;
              {bus.scl_oe, bus.sda_oe} <= pins(acc_state, 2'd0, 1'b0, bus.cmd_data[7],
                                               bus.cmd_nack, bus.scl_oe);
            end
          end
        end
        ERR: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b1;
        end
        default: begin
          if (phase_end)     cnt <= '0;
          else if (!stretch) cnt <= cnt + 1'b1;
          if (sample && (state == RBIT) && !last_bit) bus.rsp_data  <= {bus.rsp_data[6:0], bus.sda_i};
          if (sample && (state == WBIT) && last_bit)  bus.rsp_ack_n <= bus.sda_i;
          if (phase_end) begin
            if (phase != 2'd3) begin
              phase <= phase + 2'd1;
              {bus.scl_oe, bus.sda_oe} <= pins(state, phase + 2'd1, last_bit, sh[7], nack, bus.scl_oe);
            end else if (!final_elem) begin
              phase   <= 2'd0;
              bit_idx <= bit_idx + 4'd1;
              sh      <= {sh[6:0], 1'b0};
              {bus.scl_oe, bus.sda_oe} <= pins(state, 2'd0, bit_idx == 4'd7, sh[6], nack, bus.scl_oe);
            end else begin
              state         <= IDLE;
              phase         <= 2'd0;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b0;
              if (state == START) begin
                bus.bus_active <= 1'b1;
                bus.scl_oe     <= 1'b1;
              end
              if (state == STOP) bus.bus_active <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_seq.sv
// Scoreboard bench for i2c_master_seq: open-drain pull-up pins, a slave BFM that ACKs writes and
// serves read bytes, directed scenarios plus a randomized command stream against a transaction model.
`timescale 1ns/1ps
module tb_i2c_master_seq;
  localparam int N = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  i2c_master_seq_if bus();

  logic slave_sda_low = 1'b0;
  logic slave_scl_low = 1'b0;
  assign bus.sda_i = !(bus.sda_oe || slave_sda_low);
  assign bus.scl_i = !(bus.scl_oe || slave_scl_low);

  i2c_master_seq #(.CLK_DIV(N)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct {
    logic       err;
    logic [7:0] data;
    logic       ack_n;
    int         acc;
    int         lat;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // transaction-level model state
  logic       m_active = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ack_n = 1'b0;

  // slave BFM state
  int         slv_mode = 0;
  int         slv_k = 0;
  logic [7:0] slv_sh = 8'h00;
  logic [7:0] slv_rx = 8'h00;
  logic       slv_ack = 1'b0;
  logic       nack_seen = 1'b0;
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;
  int         starts = 0;
  int         stops = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor: pops the scoreboard on every rsp_valid pulse.
  initial forever begin
    @(negedge clk);
    if (resetn && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_err"},   32'(bus.rsp_err),   32'(mon_e.err));
        check({mon_e.name, "_data"},  32'(bus.rsp_data),  32'(mon_e.data));
        check({mon_e.name, "_ack_n"}, 32'(bus.rsp_ack_n), 32'(mon_e.ack_n));
        check({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  // Slave BFM and START/STOP condition detector, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (bus.scl_i && !scl_prev) begin
      if (slv_mode == 1 && slv_k < 8) slv_rx = {slv_rx[6:0], bus.sda_i};
      if (slv_mode == 2 && slv_k == 8) nack_seen = bus.sda_i;
    end
    if (!bus.scl_i && scl_prev && slv_mode != 0) begin
      slv_k++;
      slv_sh = {slv_sh[6:0], 1'b0};
      if (slv_k >= 9) begin
        slv_mode = 0;
        slave_sda_low = 1'b0;
      end else if (slv_mode == 1) begin
        slave_sda_low = (slv_k == 8) && slv_ack;
      end else begin
        slave_sda_low = (slv_k < 8) && !slv_sh[7];
      end
    end
    if (bus.scl_i && scl_prev && sda_prev && !bus.sda_i) starts++;
    if (bus.scl_i && scl_prev && !sda_prev && bus.sda_i) stops++;
    scl_prev = bus.scl_i;
    sda_prev = bus.sda_i;
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic nack,
                       input logic slv, input logic ack, input logic [7:0] rd,
                       input int extra, input string name);
    exp_t e;
    int   t;
    e.name = name;
    e.err  = (op != 2'd0) && !m_active;
    e.lat  = 2;
    if (!e.err) begin
      case (op)
        2'd0: begin e.lat = 4 * N + 1; m_active = 1'b1; end
        2'd1: begin e.lat = 36 * N + 1 + extra; m_ack_n = !(slv && ack); end
        2'd2: begin e.lat = 36 * N + 1 + extra; m_data = slv ? rd : 8'hFF; end
        default: begin e.lat = 4 * N + 1; m_active = 1'b0; end
      endcase
    end
    e.data  = m_data;
    e.ack_n = m_ack_n;
    @(negedge clk);
    if (!e.err && slv && (op == 2'd1 || op == 2'd2)) begin
      slv_mode = int'(op);
      slv_k = 0;
      slv_ack = ack;
      slv_sh = rd;
      slv_rx = 8'h00;
      slave_sda_low = (op == 2'd2) && !rd[7];
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_nack  = nack;
    t = 0;
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) check({name, "_accept_timeout"}, 32'(bus.cmd_ready), 32'd1);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_data  = 8'($urandom);
    bus.cmd_nack  = 1'($urandom);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check({name, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  logic [15:0] idle_vec;
  always_comb idle_vec = {bus.sda_oe, bus.scl_oe, bus.rsp_valid, bus.rsp_ack_n, bus.rsp_err,
                          bus.busy, bus.bus_active, bus.cmd_ready, bus.rsp_data};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         s0;
    int         bad;
    logic [1:0] op;
    logic [7:0] wd;
    logic       was_active;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_data  = 8'h00;
    bus.cmd_nack  = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("reset_state", 32'(idle_vec), 32'h0100);

    // 1: START, WRITE 0xA5 with ACK, STOP
    s0 = starts;
    issue(2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, "start1");
    wait_done("start1");
    check("start1_condition", 32'(starts - s0), 32'd1);
    check("start1_bus_active", 32'(bus.bus_active), 32'd1);
    issue(2'd1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'h00, 0, "write_a5");
    wait_done("write_a5");
    check("write_a5_sda_bits", 32'(slv_rx), 32'hA5);
    s0 = stops;
    issue(2'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, "stop1");
    wait_done("stop1");
    check("stop1_condition", 32'(stops - s0), 32'd1);
    check("stop1_bus_active", 32'(bus.bus_active), 32'd0);

    // 2: START, READ 0x3C with NACK, STOP
    issue(2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, "start2");
    wait_done("start2");
    nack_seen = 1'b0;
    issue(2'd2, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 0, "read_3c");
    wait_done("read_3c");
    check("read_3c_nack_released", 32'(nack_seen), 32'd1);

    // 3: WRITE without slave ACK
    issue(2'd1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 0, "write_noack");
    wait_done("write_noack");

    // 4: slave stretches SCL for 20 cycles in P2 of bit 3
    issue(2'd1, 8'hC3, 1'b0, 1'b0, 1'b0, 8'h00, 20, "write_stretch");
    repeat (56) @(posedge clk);
    #1 slave_scl_low = 1'b1;
    repeat (20) @(posedge clk);
    #1 slave_scl_low = 1'b0;
    wait_done("write_stretch");
    s0 = stops;
    issue(2'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, "stop2");
    wait_done("stop2");
    check("stop2_condition", 32'(stops - s0), 32'd1);

    // 5: WRITE with bus idle is rejected without pin activity
    issue(2'd1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 0, "write_rejected");
    @(negedge clk);
    check("rejected_ready_low", 32'(bus.cmd_ready), 32'd0);
    bad = 0;
    repeat (4) begin
      if (bus.sda_oe || bus.scl_oe) bad++;
      @(negedge clk);
    end
    wait_done("write_rejected");
    check("rejected_pins_quiet", 32'(bad), 32'd0);

    // 6: repeated START, then reset in the middle of a WRITE
    issue(2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, "start3");
    wait_done("start3");
    s0 = starts;
    issue(2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, "restart");
    wait_done("restart");
    check("restart_condition", 32'(starts - s0), 32'd1);
    issue(2'd1, 8'h96, 1'b0, 1'b1, 1'b1, 8'h00, 0, "write_reset");
    repeat (60) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    sb.delete();
    slv_mode = 0;
    slave_sda_low = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    m_active = 1'b0;
    m_data = 8'h00;
    m_ack_n = 1'b0;
    @(negedge clk);
    check("mid_reset_state", 32'(idle_vec), 32'h0100);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.rsp_valid) bad++;
    end
    check("mid_reset_no_rsp", 32'(bad), 32'd0);

    // randomized command stream against the transaction model
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      wd = 8'($urandom);
      was_active = m_active;
      issue(op, wd, 1'($urandom), 1'b1, 1'($urandom), 8'($urandom), 0, "rand");
      wait_done("rand");
      if (op == 2'd1 && was_active) check("rand_write_bits", 32'(slv_rx), 32'(wd));
    end
    if (m_active) begin
      issue(2'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, "stop_final");
      wait_done("stop_final");
    end
    check("final_bus_idle", 32'({bus.bus_active, bus.sda_oe, bus.scl_oe}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
